taxi_apb_drp_bridge: RTL and testbench

- APB completer that converts APB transfers into Xilinx DRP accesses (transceiver, MMCM, SYSMON dynamic reconfiguration ports).
- Sits directly downstream of the PCIe VSEC APB master, giving host config-space access to DRP-attached primitives.
- Handles partial-strobe writes by read-modify-write and bounds every DRP access with a timeout that completes the APB transfer with PSLVERR.

---
 rtl/taxi_apb_drp_bridge_if.sv | 36 +++
 rtl/taxi_apb_drp_bridge.sv | 196 +++++++++++++++++++
 tb/tb_taxi_apb_drp_bridge.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/taxi_apb_drp_bridge_if.sv
// APB bus bundle shared by the PCIe VSEC requester and its completers.
// Sideband user fields are carried for completeness; most completers ignore them.
interface taxi_apb_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int STRB_W   = DATA_W / 8,
  parameter int PAUSER_W = 1,
  parameter int PWUSER_W = 1,
  parameter int PRUSER_W = 1,
  parameter int PBUSER_W = 1
) ();
  logic [ADDR_W-1:0]   paddr;
  logic [2:0]          pprot;
  logic                psel;
  logic                penable;
  logic                pwrite;
  logic [DATA_W-1:0]   pwdata;
  logic [STRB_W-1:0]   pstrb;
  logic [PAUSER_W-1:0] pauser;
  logic [PWUSER_W-1:0] pwuser;
  logic                pready;
  logic [DATA_W-1:0]   prdata;
  logic                pslverr;
  logic [PRUSER_W-1:0] pruser;
  logic [PBUSER_W-1:0] pbuser;

  modport mst (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb, pauser, pwuser,
    input  pready, prdata, pslverr, pruser, pbuser
  );

  modport slv (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb, pauser, pwuser,
    output pready, prdata, pslverr, pruser, pbuser
  );
endinterface

// File: rtl/taxi_apb_drp_bridge.sv
// APB completer that turns each transfer into one (or, for partial-strobe writes,
// a read-modify-write pair of) Xilinx DRP accesses, bounded by a wait timeout.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | waiting for an APB access phase
// ST_RD     | DRP read issued, waiting for drp_rdy
// ST_RMW_RD | partial write: reading the old word before merging
// ST_WR     | DRP write issued, waiting for drp_rdy
// ST_DONE   | pready (and pslverr on timeout) driven for one cycle
module taxi_apb_drp_bridge #(
  parameter int DRP_ADDR_W = 10,
  parameter int DRP_DATA_W = 16,
  parameter int TIMEOUT    = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  taxi_apb_if.slv               s_apb,
  output logic [DRP_ADDR_W-1:0] drp_addr,
  output logic [DRP_DATA_W-1:0] drp_di,
  output logic                  drp_en,
  output logic                  drp_we,
  input  logic [DRP_DATA_W-1:0] drp_do,
  input  logic                  drp_rdy
);
  localparam int DATA_W     = $bits(s_apb.pwdata);
  localparam int STRB_W     = $bits(s_apb.pstrb);
  localparam int ADDR_SHIFT = $clog2(STRB_W);
  localparam int LANES      = (DRP_DATA_W + 7) / 8;
  localparam int CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  if (DATA_W > 32 || STRB_W * 8 != DATA_W) begin : g_bad_apb
    $fatal(1, "taxi_apb_drp_bridge: APB DATA_W must be <= 32 with byte strobes");
  end
  if (DRP_DATA_W > DATA_W) begin : g_bad_drp
    $fatal(1, "taxi_apb_drp_bridge: DRP_DATA_W must not exceed APB DATA_W");
  end

  typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_RMW_RD, ST_WR, ST_DONE} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [DRP_DATA_W-1:0] wdata_q, wdata_nxt;
  logic [LANES-1:0]      strb_q, strb_nxt;
  logic [DRP_ADDR_W-1:0] addr_nxt;
  logic [DRP_DATA_W-1:0] di_nxt;
  logic                  en_nxt, we_nxt;
  logic                  pready_q, pready_nxt;
  logic                  pslverr_q, pslverr_nxt;
  logic [DATA_W-1:0]     prdata_q, prdata_nxt;
  logic [LANES-1:0]      strb_in;
  logic [DRP_DATA_W-1:0] lane_mask, merged;
  logic                  accept, tmo;
  logic                  unused_apb;

  assign strb_in = s_apb.pstrb[LANES-1:0];
  assign accept  = s_apb.psel && s_apb.penable && !pready_q;
  assign tmo     = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // Strobed lanes take the new write data, the rest keep what the DRP returned.
  always_comb begin
    lane_mask = '0;
    for (int b = 0; b < DRP_DATA_W; b++) lane_mask[b] = strb_q[b / 8];
  end
  assign merged = (wdata_q & lane_mask) | (drp_do & ~lane_mask);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!s_apb.pwrite)        state_nxt = ST_RD;
          else if (&strb_in)        state_nxt = ST_WR;
          else if (strb_in == '0)   state_nxt = ST_DONE;
          else                      state_nxt = ST_RMW_RD;
        end
      end
      ST_RD, ST_WR: if (drp_rdy || tmo) state_nxt = ST_DONE;
      ST_RMW_RD: begin
        if (drp_rdy)  state_nxt = ST_WR;
        else if (tmo) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // drp_rdy is only honoured while an access is outstanding; stray pulses fall through.
  always_comb begin
    cnt_nxt     = cnt;
    wdata_nxt   = wdata_q;
    strb_nxt    = strb_q;
    addr_nxt    = drp_addr;
    di_nxt      = drp_di;
    en_nxt      = 1'b0;
    we_nxt      = 1'b0;
    pready_nxt  = 1'b0;
    pslverr_nxt = 1'b0;
    prdata_nxt  = prdata_q;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          addr_nxt  = DRP_ADDR_W'(s_apb.paddr >> ADDR_SHIFT);
          wdata_nxt = s_apb.pwdata[DRP_DATA_W-1:0];
          strb_nxt  = strb_in;
          cnt_nxt   = '0;
          if (!s_apb.pwrite) begin
            en_nxt = 1'b1;
          end else if (&strb_in) begin
            en_nxt = 1'b1;
            we_nxt = 1'b1;
            di_nxt = s_apb.pwdata[DRP_DATA_W-1:0];
          end else if (strb_in == '0) begin
            pready_nxt = 1'b1;
          end else begin
            en_nxt = 1'b1;
          end
        end
      end
      ST_RD: begin
        cnt_nxt = cnt + 1'b1;
        if (drp_rdy) begin
          prdata_nxt = DATA_W'(drp_do);
          pready_nxt = 1'b1;
        end else if (tmo) begin
          prdata_nxt  = '1;
          pready_nxt  = 1'b1;
          pslverr_nxt = 1'b1;
        end
      end
      ST_RMW_RD: begin
        cnt_nxt = cnt + 1'b1;
        if (drp_rdy) begin
          en_nxt  = 1'b1;
          we_nxt  = 1'b1;
          di_nxt  = merged;
          cnt_nxt = '0;
        end else if (tmo) begin
          pready_nxt  = 1'b1;
          pslverr_nxt = 1'b1;
        end
      end
      ST_WR: begin
        cnt_nxt = cnt + 1'b1;
        if (drp_rdy) begin
          pready_nxt = 1'b1;
        end else if (tmo) begin
          pready_nxt  = 1'b1;
          pslverr_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      drp_addr  <= '0;
      drp_di    <= '0;
      drp_en    <= 1'b0;
      drp_we    <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      cnt       <= cnt_nxt;
      wdata_q   <= wdata_nxt;
      strb_q    <= strb_nxt;
      drp_addr  <= addr_nxt;
      drp_di    <= di_nxt;
      drp_en    <= en_nxt;
      drp_we    <= we_nxt;
      pready_q  <= pready_nxt;
      pslverr_q <= pslverr_nxt;
      prdata_q  <= prdata_nxt;
    end
  end

  assign s_apb.pready  = pready_q;
  assign s_apb.pslverr = pslverr_q;
  assign s_apb.prdata  = prdata_q;
  assign s_apb.pruser  = '0;
  assign s_apb.pbuser  = '0;

  assign unused_apb = ^{s_apb.pprot, s_apb.pauser, s_apb.pwuser, s_apb.pwdata,
                        s_apb.pstrb, s_apb.paddr};
endmodule

// File: tb/tb_taxi_apb_drp_bridge.sv
// Bench for taxi_apb_drp_bridge: APB requester, DRP device with scripted latency,
// and a word-level reference model of the DRP memory.
module tb_taxi_apb_drp_bridge;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  taxi_apb_if #(.DATA_W(32), .ADDR_W(32)) apb ();

  logic [9:0]  drp_addr;
  logic [15:0] drp_di;
  logic        drp_en;
  logic        drp_we;
  logic [15:0] drp_do;
  logic        drp_rdy;

  taxi_apb_drp_bridge #(.DRP_ADDR_W(10), .DRP_DATA_W(16), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_apb    (apb),
    .drp_addr (drp_addr),
    .drp_di   (drp_di),
    .drp_en   (drp_en),
    .drp_we   (drp_we),
    .drp_do   (drp_do),
    .drp_rdy  (drp_rdy)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] dev_mem [1024];
  logic [15:0] ref_mem [1024];
  int          lat_arr [256];
  int          lat_wr    = 0;
  int          stray_req = 0;
  logic [9:0]  exp_addr  = '0;
  int          en_cnt = 0, we_cnt = 0, addr_bad = 0, overlap = 0;
  logic [15:0] last_di = '0;

  function automatic logic [15:0] init_val(input int i);
    if (i == 'h42) return 16'hBEEF;
    if (i == 'h05) return 16'h1122;
    return 16'(i * 40503 + 4660);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_lat(input int l);
    lat_arr[lat_wr % 256] = l;
    lat_wr++;
  endtask

  // DRP device: latency 0 means it never answers.
  initial begin
    int pend, lat_rd, stray_done;
    logic pend_we;
    logic [9:0] pend_addr;
    logic [15:0] pend_di;
    pend = 0; lat_rd = 0; stray_done = 0;
    pend_we = 1'b0; pend_addr = '0; pend_di = '0;
    for (int i = 0; i < 1024; i++) dev_mem[i] = init_val(i);
    drp_rdy = 1'b0;
    drp_do  = '0;
    forever begin
      @(posedge clk); #1;
      drp_rdy = 1'b0;
      if (stray_req != stray_done) begin
        stray_done++;
        drp_rdy = 1'b1;
        drp_do  = 16'($urandom);
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          drp_rdy = 1'b1;
          if (pend_we) begin
            dev_mem[pend_addr] = pend_di;
            drp_do = 16'($urandom);
          end else begin
            drp_do = dev_mem[pend_addr];
          end
        end
      end
      if (drp_en) begin
        en_cnt++;
        if (drp_we) we_cnt++;
        if (drp_addr != exp_addr) addr_bad++;
        if (pend != 0) overlap++;
        last_di   = drp_di;
        pend_we   = drp_we;
        pend_addr = drp_addr;
        pend_di   = drp_di;
        if (lat_rd != lat_wr) begin
          pend = lat_arr[lat_rd % 256];
          lat_rd++;
        end else begin
          pend = 0;
        end
      end
    end
  end

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata,
                          output logic err, output int n);
    @(posedge clk); #1;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = wr;
    apb.paddr   = addr;
    apb.pwdata  = wdata;
    apb.pstrb   = strb;
    apb.pprot   = 3'($urandom);
    apb.pauser  = 1'($urandom);
    apb.pwuser  = 1'($urandom);
    @(posedge clk); #1;
    apb.penable = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!apb.pready && n < 200);
    rdata = apb.prdata;
    err   = apb.pslverr;
    @(posedge clk); #1;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    check_eq("pready_pulse", 32'(apb.pready), 32'd0);
  endtask

  task automatic do_txn(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input int l1, input int l2);
    int a, n, exp_n, exp_en, exp_we, en0, we0, bad0, ov0;
    logic [31:0] rd, exp_rd;
    logic err, exp_err, chk_di;
    logic [15:0] old, exp_di;
    logic [1:0] ln;
    a        = int'((addr >> 2) & 32'h3FF);
    exp_addr = 10'(a);
    ln       = strb[1:0];
    old      = ref_mem[a];
    exp_rd   = '0;
    exp_err  = 1'b0;
    exp_di   = '0;
    chk_di   = 1'b0;
    if (!wr) begin
      exp_en = 1; exp_we = 0;
      push_lat(l1);
      if (l1 == 0 || l1 >= TMO) begin
        exp_err = 1'b1; exp_rd = 32'hFFFF_FFFF; exp_n = TMO + 1;
      end else begin
        exp_rd = {16'h0, old}; exp_n = l1 + 2;
      end
    end else if (ln == 2'b11) begin
      exp_en = 1; exp_we = 1;
      push_lat(l1);
      exp_n = l1 + 2;
      exp_di = wdata[15:0]; chk_di = 1'b1;
      ref_mem[a] = wdata[15:0];
    end else if (ln == 2'b00) begin
      exp_en = 0; exp_we = 0; exp_n = 1;
    end else begin
      push_lat(l1);
      if (l1 == 0) begin
        exp_en = 1; exp_we = 0; exp_err = 1'b1; exp_n = TMO + 1;
      end else begin
        push_lat(l2);
        exp_en = 2; exp_we = 1; exp_n = l1 + l2 + 3;
        exp_di = {ln[1] ? wdata[15:8] : old[15:8], ln[0] ? wdata[7:0] : old[7:0]};
        chk_di = 1'b1;
        ref_mem[a] = exp_di;
      end
    end
    en0 = en_cnt; we0 = we_cnt; bad0 = addr_bad; ov0 = overlap;
    apb_xfer(wr, addr, wdata, strb, rd, err, n);
    check_eq({tag, ".lat"}, 32'(n), 32'(exp_n));
    check_eq({tag, ".err"}, 32'(err), 32'(exp_err));
    if (!wr) check_eq({tag, ".rdata"}, rd, exp_rd);
    check_eq({tag, ".en_pulses"}, 32'(en_cnt - en0), 32'(exp_en));
    check_eq({tag, ".we_pulses"}, 32'(we_cnt - we0), 32'(exp_we));
    check_eq({tag, ".drp_addr"}, 32'(addr_bad - bad0), 32'd0);
    check_eq({tag, ".overlap"}, 32'(overlap - ov0), 32'd0);
    if (chk_di) check_eq({tag, ".drp_di"}, 32'(last_di), 32'(exp_di));
  endtask

  task automatic stray_check(input string tag);
    int en0, pr;
    en0 = en_cnt;
    pr  = 0;
    stray_req++;
    repeat (4) begin
      @(posedge clk); #1;
      if (apb.pready) pr++;
    end
    check_eq({tag, ".pready"}, 32'(pr), 32'd0);
    check_eq({tag, ".en"}, 32'(en_cnt - en0), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".drp_en"},  32'(drp_en),      32'd0);
    check_eq({tag, ".drp_we"},  32'(drp_we),      32'd0);
    check_eq({tag, ".drp_addr"}, 32'(drp_addr),   32'd0);
    check_eq({tag, ".drp_di"},  32'(drp_di),      32'd0);
    check_eq({tag, ".pready"},  32'(apb.pready),  32'd0);
    check_eq({tag, ".pslverr"}, 32'(apb.pslverr), 32'd0);
    check_eq({tag, ".prdata"},  apb.prdata,       32'd0);
    check_eq({tag, ".pruser"},  32'(apb.pruser),  32'd0);
  endtask

  initial begin
    int en0, we0, pr, mism, idx, l1, l2;
    logic wr;
    logic [31:0] addr, wdata;
    logic [3:0] strb;
    rst = 1'b1;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = '0; apb.pwdata = '0; apb.pstrb = '0;
    apb.pprot = '0; apb.pauser = '0; apb.pwuser = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    do_txn("rd_beef",  1'b0, 32'h0000_0108, 32'h0,         4'h0,    3, 0);
    do_txn("wr_full",  1'b1, 32'h0000_000C, 32'h1234_5678, 4'b1111, 2, 0);
    do_txn("rd_full",  1'b0, 32'h0000_000C, 32'h0,         4'h0,    1, 0);
    do_txn("wr_rmw",   1'b1, 32'h0000_0014, 32'h0000_AB00, 4'b0010, 2, 3);
    do_txn("rd_rmw",   1'b0, 32'h0000_0014, 32'h0,         4'h0,    2, 0);
    do_txn("wr_none",  1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'b1100, 0, 0);
    do_txn("rd_tmo",   1'b0, 32'h0000_0108, 32'h0,         4'h0,    0, 0);
    do_txn("rd_after", 1'b0, 32'h0000_0108, 32'h0,         4'h0,    4, 0);
    stray_check("stray_idle");
    do_txn("rd_edge_ok",  1'b0, 32'h0000_000C, 32'h0, 4'h0, TMO - 1, 0);
    do_txn("rd_edge_tmo", 1'b0, 32'h0000_000C, 32'h0, 4'h0, TMO,     0);
    do_txn("rmw_tmo",  1'b1, 32'h0000_0018, 32'h0000_5555, 4'b0001, 0, 0);
    do_txn("rd_untouched", 1'b0, 32'h0000_0018, 32'h0, 4'h0, 1, 0);

    // Reset pulse while the RMW read is outstanding.
    en0 = en_cnt; we0 = we_cnt;
    exp_addr = 10'h7;
    push_lat(0);
    @(posedge clk); #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
    apb.paddr = 32'h0000_001C; apb.pwdata = 32'h0000_00CD; apb.pstrb = 4'b0001;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    pr = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (apb.pready) pr++;
    end
    rst = 1'b1;
    apb.psel = 1'b0; apb.penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("mid_rst");
    stray_check("rst_stray");
    check_eq("mid_rst.pready_seen", 32'(pr), 32'd0);
    check_eq("mid_rst.en_pulses", 32'(en_cnt - en0), 32'd1);
    check_eq("mid_rst.we_pulses", 32'(we_cnt - we0), 32'd0);
    do_txn("after_rst", 1'b1, 32'h0000_001C, 32'h0000_00CD, 4'b0001, 2, 2);
    do_txn("after_rst_rd", 1'b0, 32'h0000_001C, 32'h0, 4'h0, 1, 0);

    for (int k = 0; k < 40; k++) begin
      wr    = 1'($urandom_range(0, 1));
      idx   = 'h40 + $urandom_range(0, 15);
      addr  = ($urandom & 32'hFFFF_F000) | 32'(idx << 2);
      wdata = $urandom;
      strb  = wr ? 4'($urandom) : 4'h0;
      l1    = $urandom_range(1, 6);
      l2    = $urandom_range(1, 6);
      do_txn("rnd", wr, addr, wdata, strb, l1, l2);
    end

    mism = 0;
    for (int i = 0; i < 1024; i++) if (dev_mem[i] !== ref_mem[i]) mism++;
    check_eq("mem_image", 32'(mism), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
